// File: rtl/sti_pkg.sv
// Shared types and constants for the STI serial link receiver.
package sti_pkg;

  localparam int STI_WORD_W = 32;
  localparam int STI_BYTE_W = 8;

  typedef enum logic [1:0] {
    STI_LEN_8  = 2'd0,
    STI_LEN_16 = 2'd1,
    STI_LEN_24 = 2'd2,
    STI_LEN_32 = 2'd3
  } sti_len_e;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } sti_rx_state_e;

  // Word length in bits for a length code: 8 * (code + 1).
  function automatic logic [5:0] sti_len_bits(input sti_len_e len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_rx_if.sv
// Serial input and parallel word output bundle of the STI receiver.
// Handshake: a bit transfers on every clock edge where si_valid=1; po_valid and po_err are single-cycle pulses with no backpressure.
interface sti_rx_if;
  import sti_pkg::*;

  logic                  si_data;
  logic                  si_valid;
  logic [STI_WORD_W-1:0] po_data;
  sti_len_e              po_len;
  logic                  po_valid;
  logic                  po_err;

  modport master (
    output si_data, si_valid,
    input  po_data, po_len, po_valid, po_err
  );

  modport slave (
    input  si_data, si_valid,
    output po_data, po_len, po_valid, po_err
  );

endinterface

// File: rtl/sti_rx_byte_packer.sv
// Packs arriving serial bits MSB-first into bytes and writes them to an incrementing byte address.
module sti_rx_byte_packer
  import sti_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bit_valid,
  input  logic                  bit_data,
  input  logic                  byte_last,
  output logic [STI_BYTE_W-1:0] pix_data,
  output logic [ADDR_W-1:0]     pix_addr,
  output logic                  pix_wr
);

  // Stale bits left by an aborted word are shifted out before the next write,
  // since writes only happen on the 8th bit of a byte counted from word start.
  logic [STI_BYTE_W-2:0] sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q     <= '0;
      pix_data <= '0;
      pix_addr <= '0;
      pix_wr   <= 1'b0;
    end else begin
      pix_wr <= 1'b0;
      if (pix_wr) begin
        pix_addr <= pix_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (bit_valid) begin
        sr_q <= {sr_q[STI_BYTE_W-3:0], bit_data};
        if (byte_last) begin
          pix_data <= {sr_q, bit_data};
          pix_wr   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sti_rx.sv
// STI serial-to-parallel receiver: 8/16/24/32-bit words, configurable bit order.
// Optional byte output path enabled by defining STI_RX_BYTE_OUT_EN.
module sti_rx
  import sti_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_load,
  input  logic [1:0]            cfg_length,
  input  logic                  cfg_msb,
  sti_rx_if.slave               bus,
`ifdef STI_RX_BYTE_OUT_EN
  output logic [STI_BYTE_W-1:0] pix_data,
  output logic [ADDR_W-1:0]     pix_addr,
  output logic                  pix_wr,
`endif
  output sti_rx_state_e         state
);

  sti_rx_state_e         state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  sti_len_e              len_q, len_d;
  logic                  msb_q, msb_d;
  logic [STI_WORD_W-1:0] acc_q, acc_d;
  logic [STI_WORD_W-1:0] po_data_d;
  sti_len_e              po_len_d;
  logic                  po_valid_d, po_err_d;
  logic [5:0]            n_bits;
  logic [4:0]            pos;

  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      len_q        <= STI_LEN_8;
      msb_q        <= 1'b1;
      acc_q        <= '0;
      bus.po_data  <= '0;
      bus.po_len   <= STI_LEN_8;
      bus.po_valid <= 1'b0;
      bus.po_err   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      msb_q        <= msb_d;
      acc_q        <= acc_d;
      bus.po_data  <= po_data_d;
      bus.po_len   <= po_len_d;
      bus.po_valid <= po_valid_d;
      bus.po_err   <= po_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    msb_d      = msb_q;
    acc_d      = acc_q;
    po_data_d  = bus.po_data;
    po_len_d   = bus.po_len;
    po_valid_d = 1'b0;
    po_err_d   = 1'b0;

    // A load in IDLE takes effect for a word whose first bit arrives on the same edge.
    if (state_q == RX_IDLE && cfg_load) begin
      len_d = sti_len_e'(cfg_length);
      msb_d = cfg_msb;
    end
    n_bits = sti_len_bits(len_d);
    pos    = msb_d ? 5'(n_bits - 6'd1 - {1'b0, cnt_q}) : cnt_q;

    case (state_q)
      RX_IDLE: begin
        if (bus.si_valid) begin
          acc_d      = '0;
          acc_d[pos] = bus.si_data;
          cnt_d      = 5'd1;
          state_d    = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (bus.si_valid) begin
          acc_d[pos] = bus.si_data;
          if ({1'b0, cnt_q} == n_bits - 6'd1) begin
            po_data_d  = acc_d;
            po_len_d   = len_q;
            po_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = RX_IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          acc_d    = '0;
          cnt_d    = '0;
          po_err_d = 1'b1;
          state_d  = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

`ifdef STI_RX_BYTE_OUT_EN
  sti_rx_byte_packer #(.ADDR_W(ADDR_W)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (bus.si_valid),
    .bit_data  (bus.si_data),
    .byte_last (cnt_q[2:0] == 3'd7),
    .pix_data  (pix_data),
    .pix_addr  (pix_addr),
    .pix_wr    (pix_wr)
  );
`endif

endmodule

// File: tb/tb_sti_rx.sv
// Randomized self-checking bench for sti_rx against a bit-list reference model.
module tb_sti_rx;
  import sti_pkg::*;

  localparam int ADDR_W = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_load;
  logic [1:0]    cfg_length;
  logic          cfg_msb;
  sti_rx_state_e state;
  sti_rx_if      bus ();
`ifdef STI_RX_BYTE_OUT_EN
  logic [7:0]        pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_wr;
`endif

  sti_rx #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .bus        (bus),
`ifdef STI_RX_BYTE_OUT_EN
    .pix_data   (pix_data),
    .pix_addr   (pix_addr),
    .pix_wr     (pix_wr),
`endif
    .state      (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic [1:0]  len;
    int          cyc;
  } word_t;
  typedef struct {
    logic [7:0] data;
    int         addr;
    int         cyc;
  } byte_t;

  word_t       exp_q[$];
  byte_t       exp_byte_q[$];
  int          exp_err_q[$];
  int          m_len  = 0;
  int          m_msb  = 1;
  int          m_addr = 0;
  bit          m_open = 1'b0;
  logic [31:0] m_last = '0;
  logic        bit_buf[32];

  // Arrival order of a word's bits for a given config.
  task automatic load_value(input logic [31:0] w, input int len, input int msb);
    int n;
    n = 8 * (len + 1);
    for (int i = 0; i < n; i++) bit_buf[i] = msb ? w[n-1-i] : w[i];
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int n_send, input int cfg_at, input int new_len, input int new_msb);
    int          n;
    logic [31:0] word;
    logic [7:0]  b;
    if (cfg_at == 0) begin
      m_len = new_len;
      m_msb = new_msb;
    end
    n    = 8 * (m_len + 1);
    word = '0;
    b    = '0;
    for (int i = 0; i < n_send; i++) begin
      @(negedge clk);
      bus.si_valid = 1'b1;
      bus.si_data  = bit_buf[i];
      cfg_load     = (i == cfg_at);
      cfg_length   = new_len[1:0];
      cfg_msb      = new_msb[0];
      if (m_msb != 0) word = (word << 1) + 32'(bit_buf[i]);
      else            word = word + (32'(bit_buf[i]) << i);
      b = {b[6:0], bit_buf[i]};
`ifdef STI_RX_BYTE_OUT_EN
      if (i % 8 == 7) begin
        exp_byte_q.push_back('{data: b, addr: m_addr, cyc: cyc + 1});
        m_addr = (m_addr + 1) % (1 << ADDR_W);
      end
`endif
      if (i == n - 1) begin
        exp_q.push_back('{data: word, len: 2'(m_len), cyc: cyc + 1});
        m_last = word;
      end
    end
    m_open = (n_send < n);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (i == 0 && m_open) begin
        exp_err_q.push_back(cyc + 1);
        m_open = 1'b0;
      end
      bus.si_valid = 1'b0;
      bus.si_data  = 1'($urandom);
      cfg_load     = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.si_valid = 1'b0;
    cfg_load     = 1'b0;
    m_open       = 1'b0;
    m_len        = 0;
    m_msb        = 1;
    m_addr       = 0;
    m_last       = '0;
    repeat (2) @(negedge clk);
    check("rst_po_data", bus.po_data, 32'h0);
    check("rst_po_len", 32'(bus.po_len), 32'h0);
    check("rst_po_valid", 32'(bus.po_valid), 32'h0);
    check("rst_po_err", 32'(bus.po_err), 32'h0);
    check("rst_state", 32'(state), 32'(RX_IDLE));
`ifdef STI_RX_BYTE_OUT_EN
    check("rst_pix_data", 32'(pix_data), 32'h0);
    check("rst_pix_addr", 32'(pix_addr), 32'h0);
    check("rst_pix_wr", 32'(pix_wr), 32'h0);
`endif
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  word_t mon_w;
  byte_t mon_b;
  int    mon_c;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.po_valid) begin
        check("po_valid_expected", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          mon_w = exp_q.pop_front();
          check("po_data", bus.po_data, mon_w.data);
          check("po_len", 32'(bus.po_len), 32'(mon_w.len));
          check("po_valid_cyc", cyc, mon_w.cyc);
        end
      end
      if (bus.po_err) begin
        check("po_err_expected", 32'(exp_err_q.size() > 0), 32'h1);
        if (exp_err_q.size() > 0) begin
          mon_c = exp_err_q.pop_front();
          check("po_err_cyc", cyc, mon_c);
        end
      end
`ifdef STI_RX_BYTE_OUT_EN
      if (pix_wr) begin
        check("pix_wr_expected", 32'(exp_byte_q.size() > 0), 32'h1);
        if (exp_byte_q.size() > 0) begin
          mon_b = exp_byte_q.pop_front();
          check("pix_data", 32'(pix_data), 32'(mon_b.data));
          check("pix_addr", 32'(pix_addr), mon_b.addr);
          check("pix_wr_cyc", cyc, mon_b.cyc);
        end
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] val;
  int          r_len, r_msb, r_n, r_send, r_cfg;

  initial begin
    reset        = 1'b1;
    bus.si_valid = 1'b0;
    bus.si_data  = 1'b0;
    cfg_load     = 1'b0;
    cfg_length   = 2'd0;
    cfg_msb      = 1'b0;
    do_reset();
    idle(2);

    // 16-bit MSB-first word
    load_value(32'hA5C3, 1, 1);
    send(16, 0, 1, 1);
    idle(3);
    check("t1_po_data", bus.po_data, 32'h0000A5C3);
`ifdef STI_RX_BYTE_OUT_EN
    check("t1_pix_addr", 32'(pix_addr), 32'd2);
`endif

    // 32-bit LSB-first word
    load_value(32'h12345678, 3, 0);
    send(32, 0, 3, 0);
    idle(3);
    check("t2_po_data", bus.po_data, 32'h12345678);

    // back-to-back 8-bit words
    load_value(32'h3C, 0, 1);
    send(8, 0, 0, 1);
    load_value(32'hFF, 0, 1);
    send(8, -1, 0, 0);
    idle(3);
    check("t3_po_data", bus.po_data, 32'hFF);

    // 24-bit word aborted after 10 bits
    load_value($urandom, 2, 1);
    send(10, 0, 2, 1);
    idle(3);
    check("t4_po_hold", bus.po_data, 32'hFF);
    check("t4_po_len_hold", 32'(bus.po_len), 32'h0);
`ifdef STI_RX_BYTE_OUT_EN
    check("t4_pix_addr", 32'(pix_addr), m_addr);
`endif

    // 256 bytes, mostly back-to-back, pix_addr wraps
    r_msb = int'($urandom_range(0, 1));
    for (int k = 0; k < 256; k++) begin
      load_value($urandom, 0, r_msb);
      send(8, (k == 0) ? 0 : -1, 0, r_msb);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(3);
`ifdef STI_RX_BYTE_OUT_EN
    check("t5_pix_addr", 32'(pix_addr), m_addr);
`endif

    // cfg_load mid-word is ignored
    val = 32'($urandom_range(0, 255));
    load_value(val, 0, m_msb);
    send(8, 5, 3, 1);
    idle(3);
    check("t6_po_data", bus.po_data, val);
    check("t6_po_len", 32'(bus.po_len), 32'h0);

    // reset in the middle of a 32-bit word, then default config applies
    load_value($urandom, 3, 1);
    send(13, 0, 3, 1);
    do_reset();
    val = 32'($urandom_range(0, 255));
    load_value(val, 0, 1);
    send(8, -1, 3, 0);
    idle(3);
    check("t7_po_data", bus.po_data, val);
    check("t7_po_len", 32'(bus.po_len), 32'h0);

    // randomized words, configs, aborts and gaps
    for (int k = 0; k < 60; k++) begin
      r_cfg = ($urandom_range(0, 2) == 0) ? -1 : 0;
      r_len = (r_cfg == 0) ? int'($urandom_range(0, 3)) : m_len;
      r_msb = (r_cfg == 0) ? int'($urandom_range(0, 1)) : m_msb;
      r_n   = 8 * (r_len + 1);
      r_send = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, r_n - 1)) : r_n;
      load_value($urandom, r_len, r_msb);
      send(r_send, r_cfg, r_len, r_msb);
      if (r_send < r_n) idle(int'($urandom_range(1, 3)));
      else              idle(int'($urandom_range(0, 2)));
    end
    idle(5);

    check("words_left", exp_q.size(), 32'h0);
    check("errs_left", exp_err_q.size(), 32'h0);
    check("bytes_left", exp_byte_q.size(), 32'h0);
    check("final_state", 32'(state), 32'(RX_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
